// File: rtl/s1_neuron_pkg.sv
// Shared constants and the output saturate/ReLU helper for the s1 neuron.
package s1_neuron_pkg;

    localparam int N_DEF  = 8;
    localparam int DW_DEF = 32;
    localparam int IW_DEF = 12;
    localparam int FW_DEF = 20;

    localparam logic [DW_DEF-1:0] ONE_Q = DW_DEF'(1) << FW_DEF;

    // Working widths wide enough for any sane accumulator / output
    localparam int ACC_MAX = 128;
    localparam int SAT_W   = 64;

    // Rescale a Q(2I).(2F) accumulator to Q(I).(F), clamp to the signed
    // dw-bit range, then ReLU. Negative values clamp low and then go to 0.
    function automatic logic [SAT_W-1:0] sat_relu(
        input logic signed [ACC_MAX-1:0] acc,
        input int                        dw,
        input int                        fw
    );
        logic signed [ACC_MAX-1:0] s;
        logic signed [ACC_MAX-1:0] pmax;
        s    = acc >>> fw;
        pmax = (ACC_MAX'(1) << (dw - 1)) - ACC_MAX'(1);
        if (s[ACC_MAX-1])
            return '0;
        else if (s > pmax)
            return pmax[SAT_W-1:0];
        return s[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/s1_adder_tree.sv
// Balanced signed adder tree with a registered sum; grows log2(N) bits so it never overflows.
module s1_adder_tree #(
    parameter  int N    = 8,
    parameter  int IN_W = 64,
    localparam int OW   = IN_W + $clog2(N)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N-1:0][IN_W-1:0]     in_i,
    output logic signed [OW-1:0]       sum_o
);

    // Heap-ordered nodes: leaves at N-1..2N-2, root at 0
    logic signed [OW-1:0] node [2*N-1];

    always_comb begin
        node = '{default: '0};
        for (int i = 0; i < N; i++)
            node[N-1+i] = {{(OW-IN_W){in_i[i][IN_W-1]}}, in_i[i]};
        for (int k = N - 2; k >= 0; k--)
            node[k] = node[2*k+1] + node[2*k+2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_o <= '0;
        else        sum_o <= node[0];
    end

endmodule

// File: rtl/s1_neuron.sv
// Fixed-point neuron H = ReLU(sat(sum X[i]*W[i])), 3-stage pipeline, one vector per cycle.
module s1_neuron
    import s1_neuron_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF,
    parameter int IW = IW_DEF,
    parameter int FW = FW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [N*DW-1:0] X,
    input  logic [N*DW-1:0] W,
    output logic            out_valid,
    output logic [DW-1:0]   H
);

    localparam int STAGES = 3;
    localparam int PW     = 2 * DW;
    localparam int ACCW   = PW + $clog2(N);

    logic [STAGES:1]         vld_q;
    logic [N-1:0][PW-1:0]    p_d, p_q;
    logic signed [ACCW-1:0]  acc_q;
    logic [DW-1:0]           h_d, h_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= {vld_q[STAGES-1:1], in_valid};
    end

    // Stage 1: full-width signed products, loaded every cycle
    for (genvar i = 0; i < N; i++) begin : g_mul
        assign p_d[i] = PW'($signed(X[i*DW +: DW])) * PW'($signed(W[i*DW +: DW]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) p_q <= '0;
        else        p_q <= p_d;
    end

    // Stage 2: reduction
    s1_adder_tree #(
        .N    (N),
        .IN_W (PW)
    ) u_tree (
        .clk   (clk),
        .rst_n (rst_n),
        .in_i  (p_q),
        .sum_o (acc_q)
    );

    // Stage 3: rescale, clamp, ReLU; H only updates on a valid result
    always_comb begin
        h_d = DW'(sat_relu({{(ACC_MAX-ACCW){acc_q[ACCW-1]}}, acc_q}, IW + FW, FW));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          h_q <= '0;
        else if (vld_q[2])   h_q <= h_d;
    end

    assign out_valid = vld_q[STAGES];
    assign H         = h_q;

endmodule

// File: tb/tb_s1_neuron.sv
// Directed bench for s1_neuron: latency, arithmetic corners, hold, reset flush, back-to-back flow.
module tb_s1_neuron;
    import s1_neuron_pkg::*;

    localparam int N  = N_DEF;
    localparam int DW = DW_DEF;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b1;
    logic            in_valid = 1'b0;
    logic [N*DW-1:0] X        = '0;
    logic [N*DW-1:0] W        = '0;
    logic            out_valid;
    logic [DW-1:0]   H;

    int passed = 0;
    int total  = 0;
    int nfail  = 0;

    s1_neuron #(.N(N), .DW(DW), .IW(IW_DEF), .FW(FW_DEF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .X         (X),
        .W         (W),
        .out_valid (out_valid),
        .H         (H)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] rep(input logic [DW-1:0] v);
        return {N{v}};
    endfunction

    function automatic logic [N*DW-1:0] lane2(input logic [DW-1:0] l0, input logic [DW-1:0] l1);
        logic [N*DW-1:0] r;
        r = '0;
        r[DW-1:0]    = l0;
        r[2*DW-1:DW] = l1;
        return r;
    endfunction

    // One isolated vector: checks exact 3-edge latency, value, then hold
    task automatic send(input string tag, input logic [N*DW-1:0] xv,
                        input logic [N*DW-1:0] wv, input logic [DW-1:0] exp);
        X = xv; W = wv; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk({tag, "_early"}, DW'(out_valid), DW'(0));
        tick();
        chk({tag, "_vld"}, DW'(out_valid), DW'(1));
        chk({tag, "_H"}, H, exp);
        tick();
        chk({tag, "_drop"}, DW'(out_valid), DW'(0));
        chk({tag, "_hold"}, H, exp);
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_H", H, '0);
        chk("rst_vld", DW'(out_valid), DW'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_vld", DW'(out_valid), DW'(0));

        // Arithmetic corners
        send("ones",  rep(ONE_Q), rep(ONE_Q), 32'h0080_0000);
        send("tiny",  lane2(32'h0000_0001, 32'h0), lane2(32'h0000_0001, 32'h0), 32'h0);
        send("half",  rep(32'h0008_0000), rep(32'h0008_0000), 32'h0020_0000);
        send("relu",  lane2(32'hFFF0_0000, 32'h0), lane2(ONE_Q, 32'h0), 32'h0);
        send("mixed", lane2(32'h0030_0000, 32'hFFF0_0000), lane2(ONE_Q, ONE_Q), 32'h0020_0000);
        send("satp",  rep(32'h7FFF_FFFF), rep(32'h7FFF_FFFF), 32'h7FFF_FFFF);

        // Reset with two vectors in flight
        X = rep(ONE_Q); W = rep(ONE_Q); in_valid = 1'b1;
        tick();
        X = rep(32'h0008_0000); W = rep(32'h0008_0000);
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_H", H, '0);
        chk("midrst_vld", DW'(out_valid), DW'(0));
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("flush_vld%0d", c), DW'(out_valid), DW'(0));
            chk($sformatf("flush_H%0d", c), H, '0);
        end

        send("satn", rep(32'h8000_0000), rep(32'h7FFF_FFFF), 32'h0);
        send("again", rep(32'h0008_0000), rep(32'h0008_0000), 32'h0020_0000);

        // Idle cycles with changing data must not produce output
        for (int c = 0; c < 5; c++) begin
            X = rep($urandom); W = rep($urandom);
            tick();
            chk($sformatf("idle_vld%0d", c), DW'(out_valid), DW'(0));
            chk($sformatf("idle_H%0d", c), H, 32'h0020_0000);
        end

        // Back-to-back: 8.0, 2.0, 0
        X = rep(ONE_Q); W = rep(ONE_Q); in_valid = 1'b1;
        tick();
        X = rep(32'h0008_0000); W = rep(32'h0008_0000);
        tick();
        X = lane2(32'hFFF0_0000, 32'h0); W = lane2(ONE_Q, 32'h0);
        tick();
        in_valid = 1'b0;
        chk("b2b0_vld", DW'(out_valid), DW'(1));
        chk("b2b0_H", H, 32'h0080_0000);
        tick();
        chk("b2b1_vld", DW'(out_valid), DW'(1));
        chk("b2b1_H", H, 32'h0020_0000);
        tick();
        chk("b2b2_vld", DW'(out_valid), DW'(1));
        chk("b2b2_H", H, 32'h0);
        tick();
        chk("b2b_drop", DW'(out_valid), DW'(0));
        chk("b2b_hold", H, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
